inv_mix_columns_seq: RTL
========================

# inv_mix_columns_seq

Iterative AES InvMixColumns engine for the decryption datapath. It accepts one 128-bit AES state over a valid/ready handshake and transforms one column per clock using GF(2^8) constant multiplication by 0e/0b/0d/09. It presents the result over a second valid/ready handshake. It is the decrypt-side counterpart of the MixColumns logic built on the existing `Mul`/`xtime`/`eightbitxor` primitives, and it reuses those primitives for all field arithmetic.

## Interface
Parameters:
- None. The block is fixed to the AES-128 state, 4 columns of 4 bytes.

Ports:
- clk  input  1  single clock for the block; all state updates on its rising edge
- rst_n  input  1  reset, asynchronous, active-low
- in_valid  input  1  state_in holds a state to be transformed
- in_ready  output  1  block can accept a state this cycle
- state_in  input  128  input state; byte k = state_in[127-8k -: 8]; column c = bytes 4c..4c+3, row r = byte 4c+r
- out_valid  output  1  state_out holds a finished result
- out_ready  input  1  downstream accepts state_out this cycle
- state_out  output  128  transformed state, same byte ordering as state_in

## Operation
- Per column (s0..s3 are rows 0..3):
  - s0' = 0e·s0 ^ 0b·s1 ^ 0d·s2 ^ 09·s3
  - s1' = 09·s0 ^ 0e·s1 ^ 0b·s2 ^ 0d·s3
  - s2' = 0d·s0 ^ 09·s1 ^ 0e·s2 ^ 0b·s3
  - s3' = 0b·s0 ^ 0d·s1 ^ 09·s2 ^ 0e·s3
- Field arithmetic:
  - Multiplication is in GF(2^8) with reduction polynomial x^8+x^4+x^3+x+1 (0x11B).
  - Addition is bytewise XOR. All widths are 8 bits; there is no carry.
- Datapath:
  - One shared column unit (16 constant multiplies, XOR trees), used once per BUSY cycle.
  - A 128-bit input register (src) and a 128-bit result register (dst).
- FSM states: IDLE, BUSY, DONE.
  - IDLE: in_ready=1, out_valid=0. On in_valid&&in_ready, latch state_in into src, set col=0, go to BUSY.
  - BUSY: in_ready=0. Each cycle, compute column col from src and write it into dst column col; col increments. After the col=3 write, go to DONE.
  - DONE: out_valid=1, state_out=dst. On out_ready, go to IDLE; otherwise hold.
- col is a 2-bit counter, used only in BUSY. It wraps 3→0 on exit and is reset to 0 on every acceptance.
- Data stability:
  - state_in is sampled only on the accept edge; later changes are ignored.
  - state_out and out_valid stay stable while out_valid=1 and out_ready=0.
- Reset (rst_n=0, any time including mid-BUSY or DONE):
  - FSM goes to IDLE immediately; col=0; src=0; dst=0.
  - Outputs: in_ready=1, out_valid=0, state_out=0.
  - Any in-flight state is discarded; no partial result is ever presented.
- out_ready while not in DONE is ignored. in_valid outside IDLE is ignored; the upstream holds it until in_ready.

## Timing
- in_ready and out_valid are decoded from registered FSM state only; there is no combinational path from input to output.
- Accept on edge E0. Columns 0..3 are written on edges E1..E4. out_valid=1 starting the cycle after E4, so latency is 4 cycles from acceptance to out_valid.
- An output handshake on edge Ed returns the block to IDLE; in_ready=1 the cycle after Ed. A new input cannot be accepted on the same edge as the output handshake.
- Best-case throughput is one state per 6 cycles: accept, 4 BUSY cycles, 1 DONE cycle.
- A result is never overwritten before the output handshake; DONE stalls indefinitely under backpressure.
- The critical path is one column: constant multiply plus a 4-input XOR per byte.

## Test plan
- FIPS-197 columns:
  - state_in = 8e4da1bc_9fdc589d_01010101_d5d5d7d6, in_valid pulse, out_ready=1
  - -> state_out = db135345_f20a225c_01010101_d4d4d4d5, out_valid rising exactly 4 cycles after accept, in_ready=0 throughout BUSY/DONE.
- Backpressure:
  - state_in = 4d7ebdf8 repeated 4×, out_ready=0 for 10 cycles, then 1
  - -> state_out = 2d26314c ×4, held stable with out_valid=1 for all 10 cycles; IDLE the cycle after the handshake.
- Input isolation:
  - Change state_in to ffffffff_… and keep in_valid=1 during BUSY
  - -> result unchanged and no second accept until IDLE. Then the second state 00000000_… -> all-zero output.
- Reset mid-operation:
  - Assert rst_n=0 asynchronously at col=2
  - -> in_ready=1, out_valid=0, state_out=0 immediately. After release, a new state is processed correctly with full 4-cycle latency.
- Back-to-back:
  - 3 states streamed with in_valid and out_ready held high
  - -> each result correct and in order; accepts spaced exactly 6 cycles apart.
- Random:
  - 1000 random states
  - -> state_out matches a reference model. Applying the MixColumns model to state_out returns state_in.

Source files
------------

// File: rtl/inv_mix_columns_seq.sv
// -----------------------------------------------------------------------------
// inv_mix_columns_seq
//
// Iterative AES InvMixColumns engine for the decryption datapath. One 128-bit
// state is accepted over a valid/ready handshake, transformed one column per
// clock through a single shared column unit, and presented over a second
// valid/ready handshake. Field arithmetic is built from the xtime /
// eightbitxor / constant-multiply primitives shared with the encrypt side.
//
// Ports:
//   clk        in   1    rising-edge clock
//   rst_n      in   1    asynchronous active-low reset
//   in_valid   in   1    state_in carries a state to transform
//   in_ready   out  1    block is idle and can accept a state
//   state_in   in   128  byte k = state_in[127-8k -: 8], column c = bytes 4c..4c+3
//   out_valid  out  1    state_out carries a finished result
//   out_ready  in   1    downstream accepts state_out
//   state_out  out  128  transformed state, same byte ordering as state_in
//
// Latency is 4 cycles from the accept edge to out_valid; a new state can be
// accepted the cycle after the output handshake (one state per 6 cycles).
// -----------------------------------------------------------------------------
module inv_mix_columns_seq (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] state_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] state_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t       state;
  logic [1:0]   col;
  logic [127:0] src;
  logic [127:0] dst;
  logic [31:0]  col_in;
  logic [31:0]  col_out;
  logic [7:0]   s0, s1, s2, s3;

  // Multiply by x modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] eightbitxor(input logic [7:0] a,
                                             input logic [7:0] b,
                                             input logic [7:0] c,
                                             input logic [7:0] d);
    return a ^ b ^ c ^ d;
  endfunction

  // Constant multiply by a 4-bit coefficient (0e/0b/0d/09 here). The
  // coefficient is always a literal at the call site, so the unused terms
  // fold away and each multiply reduces to a small XOR network.
  function automatic logic [7:0] mul(input logic [7:0] b, input logic [3:0] k);
    logic [7:0] x2;
    logic [7:0] x4;
    logic [7:0] x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return (k[0] ? b  : 8'h00) ^
           (k[1] ? x2 : 8'h00) ^
           (k[2] ? x4 : 8'h00) ^
           (k[3] ? x8 : 8'h00);
  endfunction

  // Column selector feeding the shared column unit.
  always_comb begin
    col_in = src[31:0];
    case (col)
      2'd0:    col_in = src[127:96];
      2'd1:    col_in = src[95:64];
      2'd2:    col_in = src[63:32];
      default: col_in = src[31:0];
    endcase
  end

  assign s0 = col_in[31:24];
  assign s1 = col_in[23:16];
  assign s2 = col_in[15:8];
  assign s3 = col_in[7:0];

  // Shared column unit: 16 constant multiplies and four 4-input XOR trees.
  always_comb begin
    col_out = {
      eightbitxor(mul(s0, 4'he), mul(s1, 4'hb), mul(s2, 4'hd), mul(s3, 4'h9)),
      eightbitxor(mul(s0, 4'h9), mul(s1, 4'he), mul(s2, 4'hb), mul(s3, 4'hd)),
      eightbitxor(mul(s0, 4'hd), mul(s1, 4'h9), mul(s2, 4'he), mul(s3, 4'hb)),
      eightbitxor(mul(s0, 4'hb), mul(s1, 4'hd), mul(s2, 4'h9), mul(s3, 4'he))
    };
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      col   <= '0;
      src   <= '0;
      dst   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            src   <= state_in;
            col   <= '0;
            state <= BUSY;
          end
        end
        BUSY: begin
          case (col)
            2'd0:    dst[127:96] <= col_out;
            2'd1:    dst[95:64]  <= col_out;
            2'd2:    dst[63:32]  <= col_out;
            default: dst[31:0]   <= col_out;
          endcase
          col <= col + 2'd1;
          if (col == 2'd3) begin
            state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Handshake outputs decode registered state only. state_out is masked
  // outside DONE so a partially written dst is never visible.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign state_out = (state == DONE) ? dst : '0;

endmodule
